fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares the single FP32 adder datapath between two requesters. Accepts operand pairs from requester 0 and requester 1 with valid/ready handshakes and arbitrates round-robin. It issues one operation at a time to the adder with a start pulse, waits for done or a watchdog timeout, and returns the sum to the winning requester as a one-cycle response pulse. It sits between the operand sources and the adder core, which it sequences.

## Interface
Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single)
- MAX_WAIT, 64, WAIT-state cycles allowed before timeout (range 2..255)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Clear  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_a, req1_b: same for requester 1
- rsp0_valid  out  1  one-cycle result pulse to requester 0 (no backpressure)
- rsp0_data  out  WIDTH  sum, valid with rsp0_valid
- rsp0_err  out  1  timeout flag, valid with rsp0_valid
- rsp1_valid, rsp1_data, rsp1_err: same for requester 1
- add_start  out  1  one-cycle pulse: adder begins on add_a/add_b
- add_a, add_b  out  WIDTH  registered operands, stable from ISSUE until next accept
- add_abort  out  1  one-cycle pulse on timeout; adder must drop its operation
- add_done  in  1  adder result valid this cycle
- add_sum  in  WIDTH  adder result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any reqN_valid, pick a winner. Winner's reqN_ready is high combinationally this cycle; the other ready stays 0. On the handshake, latch operands into add_a/add_b, store the grant tag, and go to ISSUE. Both ready outputs are 0 in all other states.
- Arbitration: round-robin on last_grant. With both valid, the requester not equal to last_grant wins. With only one valid, that requester wins.
- ISSUE: add_start=1 for exactly one cycle. Clear the wait counter and go to WAIT.
- WAIT: if add_done=1, capture add_sum, set err=0, and go to RESP. Otherwise increment the counter. When the counter reaches MAX_WAIT-1 with no done, set result=32'h7FC00000 (qNaN), set err=1, pulse add_abort, and go to RESP. add_done on that same final cycle takes priority over timeout.
- RESP: drive rspN_valid=1 with data/err on the granted side only. Set last_grant to the grant tag and go to IDLE.
- add_done outside WAIT is ignored.
- rspN_data and rspN_err hold their last values between pulses. rspN_valid is a pulse only.
- Clear (any state, including mid-WAIT) takes effect at the next edge:
  - state → IDLE, last_grant → 1 (requester 0 wins first tie)
  - counter, add_a, add_b, rsp data → 0; err flags → 0
  - all pulses and ready outputs → 0 during the Clear cycle
  - in-flight operation dropped with no response

## Timing
- Reset values: every output is 0, including busy, both ready signals, and both rsp_valid signals.
- Accept handshake in cycle T (IDLE). add_start in T+1 (ISSUE). First WAIT cycle is T+2.
- add_done sampled in cycle T+2+d (d ≥ 0) → rspN_valid in T+3+d, IDLE in T+4+d, next accept possible in T+4+d.
- Minimum occupancy is 4 cycles per operation (adder done in the first WAIT cycle).
- Timeout: with no done, WAIT lasts exactly MAX_WAIT cycles. add_abort is asserted in the cycle after the last WAIT cycle (same cycle as rsp_valid with err=1).
- A requester holding valid after its accept is not re-accepted until IDLE. Its data must then be a new pair; the arbiter does not deduplicate.

## Test plan
- Reset: Clear high for 2 cycles with both valids high → all outputs 0, no ready; after release, req0 accepted first.
- Single op: req0 a=3F800000, b=40000000; adder model sets done one cycle after start with sum=40400000 → add_start at T+1, rsp0_valid at T+3 with data=40400000, err=0; rsp1 silent.
- Round-robin: both valids held continuously for 4 ops → grant order 0,1,0,1; each response goes only to the granted side; each op takes 4 cycles.
- Variable latency: done delayed 10 WAIT cycles → rsp at T+13; add_done pulses injected in IDLE/RESP are ignored (no extra rsp).
- Timeout: MAX_WAIT=8, adder never asserts done → after 8 WAIT cycles, rsp1_valid with data=7FC00000, err=1, add_abort pulse in the same cycle; next op proceeds normally. Done on the 8th WAIT cycle → normal result, err=0, no abort.
- Clear mid-WAIT: assert Clear during the 3rd WAIT cycle → next cycle IDLE, busy=0, no response pulse; later done ignored; next accept favors req0.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// Bus bundle between the operand requesters, the shared FP32 adder and the
// arbiter. The arbiter uses the slave view; the environment (requesters and
// adder core) uses the master view.
interface fp_add_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_err;

  logic             add_start;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_abort;
  logic             add_done;
  logic [WIDTH-1:0] add_sum;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_done, add_sum,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    output add_start, add_a, add_b, add_abort,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_done, add_sum,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    input  add_start, add_a, add_b, add_abort,
    input  busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP32 adder between two requesters.
// One operation in flight at a time: accept -> start pulse -> wait for done
// (or watchdog timeout, answered with a quiet NaN and err) -> response pulse.
module fp_add_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic            Clk,
  input  logic            Clear,
  fp_add_arbiter_if.slave bus
);

  localparam logic [WIDTH-1:0] QNAN     = WIDTH'(32'h7FC0_0000);
  localparam logic [7:0]       CNT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             grant_reg;
  logic [7:0]       cnt_reg;
  logic [WIDTH-1:0] add_a_reg, add_b_reg;
  logic [WIDTH-1:0] rsp_data_reg [2];
  logic             rsp_err_reg  [2];

  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];

  logic             win;
  logic [1:0]       ready;
  logic [1:0]       rsp_valid;
  logic             accept, finish, timeout, start, abort;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_a[0]  = bus.req0_a;
  assign req_b[0]  = bus.req0_b;
  assign req_a[1]  = bus.req1_a;
  assign req_b[1]  = bus.req1_b;

  // On a tie the side that did not win last time goes first; otherwise the
  // only valid side wins.
  assign win = (&req_valid) ? ~last_grant_reg : req_valid[1];

  // Next-state and per-cycle pulse decode; Clear forces IDLE and silences
  // every pulse and ready in the same cycle.
  always_comb begin
    state_next = state_reg;
    ready      = 2'b00;
    rsp_valid  = 2'b00;
    accept     = 1'b0;
    finish     = 1'b0;
    timeout    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|req_valid) begin
          ready[win] = 1'b1;
          accept     = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start      = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A done on the final allowed cycle still wins over the timeout.
        if (bus.add_done) begin
          finish     = 1'b1;
          state_next = S_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          finish     = 1'b1;
          timeout    = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[grant_reg] = 1'b1;
        abort                = rsp_err_reg[grant_reg];
        state_next           = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (Clear) begin
      state_next = S_IDLE;
      ready      = 2'b00;
      rsp_valid  = 2'b00;
      accept     = 1'b0;
      finish     = 1'b0;
      timeout    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
    end
  end

  // FSM state, grant bookkeeping, operand latch and the WAIT-cycle counter.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      cnt_reg        <= '0;
      add_a_reg      <= '0;
      add_b_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        grant_reg <= win;
        add_a_reg <= req_a[win];
        add_b_reg <= req_b[win];
      end
      if (state_reg == S_ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == S_WAIT && !finish) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
      if (state_reg == S_RESP) begin
        last_grant_reg <= grant_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rsp
      // Each side keeps its last result and error flag until its next completion.
      always_ff @(posedge Clk) begin
        if (Clear) begin
          rsp_data_reg[gi] <= '0;
          rsp_err_reg[gi]  <= 1'b0;
        end else if (finish && (int'(grant_reg) == gi)) begin
          rsp_data_reg[gi] <= timeout ? QNAN : bus.add_sum;
          rsp_err_reg[gi]  <= timeout;
        end
      end
    end
  endgenerate

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp0_data  = rsp_data_reg[0];
  assign bus.rsp0_err   = rsp_err_reg[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp1_data  = rsp_data_reg[1];
  assign bus.rsp1_err   = rsp_err_reg[1];
  assign bus.add_start  = start;
  assign bus.add_a      = add_a_reg;
  assign bus.add_b      = add_b_reg;
  assign bus.add_abort  = abort;
  assign bus.busy       = (state_reg != S_IDLE);

endmodule
